// File: rtl/alu_slice_sequencer.sv
// Bit-serial sequencer for the 1-bit ALU slice: streams a WIDTH-bit operand pair
// LSB-first through the slice and reassembles the result, generating INC carries locally.
module alu_slice_sequencer #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_sel,
    input  logic             slice_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_err
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and its payload stable until that edge.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [WIDTH-2:0]   res_sh;
    logic [WIDTH-1:0]   res_nx;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic               carry, carry_nx;
    logic               op_legal;

    assign op_legal = (in_op <= OP_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_sel = 3'b000;
        res_nx    = {slice_r, res_sh};
        carry_nx  = a_sh[0] & carry;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = op_legal ? RUN : DONE;
            end
            RUN: begin
                slice_a = a_sh[0];
                case (op_q)
                    // INC is a ripple of XOR with a locally generated carry.
                    OP_INC: begin
                        slice_sel = OP_XOR;
                        slice_b   = carry;
                    end
                    OP_NOT: slice_sel = op_q;
                    default: begin
                        slice_sel = op_q;
                        slice_b   = b_sh[0];
                    end
                endcase
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            op_q       <= 3'b000;
            cnt        <= '0;
            carry      <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op_legal) begin
                            a_sh  <= in_a;
                            b_sh  <= in_b;
                            op_q  <= in_op;
                            carry <= (in_op == OP_INC);
                            cnt   <= '0;
                        end else begin
                            out_result <= '0;
                            out_carry  <= 1'b0;
                            out_err    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    res_sh <= res_nx[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (op_q == OP_INC) carry <= carry_nx;
                    if (cnt == LAST) begin
                        out_result <= res_nx;
                        out_carry  <= (op_q == OP_INC) & carry_nx;
                        out_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: behavioural 1-bit slice, arithmetic reference model,
// directed scenarios followed by randomized operations.
module tb_alu_slice_sequencer;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = 3'b000;
    logic         slice_a, slice_b;
    logic [2:0]   slice_sel;
    logic         slice_r;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_carry, out_err;

    int checks = 0;
    int errors = 0;

    alu_slice_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .slice_a(slice_a), .slice_b(slice_b), .slice_sel(slice_sel), .slice_r(slice_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // The 1-bit ALU slice itself.
    always_comb begin
        case (slice_sel)
            3'b000:  slice_r = slice_a & slice_b;
            3'b001:  slice_r = slice_a | slice_b;
            3'b010:  slice_r = slice_a ^ slice_b;
            3'b011:  slice_r = ~slice_a;
            default: slice_r = 1'b0;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                  output logic [W-1:0] res, output logic cy, output logic err);
        logic [W:0] sum;
        res = '0;
        cy  = 1'b0;
        err = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: res = ~a;
            3'b100: begin
                sum = {1'b0, a} + 1;
                res = sum[W-1:0];
                cy  = sum[W];
            end
            default: err = 1'b1;
        endcase
    endfunction

    // Expected slice inputs for bit i: INC carries in a 1 iff all lower A bits are ones.
    task automatic check_slice(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input int i);
        logic [W-1:0] mask;
        logic exp_b;
        logic [2:0] exp_sel;
        mask = (i == 0) ? '0 : ({W{1'b1}} >> (W - i));
        case (op)
            3'b100:  begin exp_sel = 3'b010; exp_b = ((a & mask) == mask); end
            3'b011:  begin exp_sel = op;     exp_b = 1'b0; end
            default: begin exp_sel = op;     exp_b = b[i]; end
        endcase
        check($sformatf("slice_a[%0d]", i), W'(slice_a), W'(a[i]));
        check($sformatf("slice_b[%0d]", i), W'(slice_b), W'(exp_b));
        check($sformatf("slice_sel[%0d]", i), W'(slice_sel), W'(exp_sel));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input bit bp);
        logic [W-1:0] exp_res;
        logic exp_cy, exp_err;
        int k;
        bit got;
        model(a, b, op, exp_res, exp_cy, exp_err);
        check("in_ready_idle", W'(in_ready), W'(1));
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = !bp;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        k = 0;
        got = 0;
        while (!got && k < W + 5) begin
            @(negedge clk);
            k++;
            if (out_valid) got = 1;
            else if (!exp_err && k <= W) check_slice(a, b, op, k - 1);
        end
        check("latency", W'(k), exp_err ? W'(1) : W'(W + 1));
        check("out_result", out_result, exp_res);
        check("out_carry", W'(out_carry), W'(exp_cy));
        check("out_err", W'(out_err), W'(exp_err));
        check("slice_sel_done", W'(slice_sel), W'(0));
        if (bp) begin
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                check("bp_valid", W'(out_valid), W'(1));
                check("bp_result", out_result, exp_res);
                check("bp_in_ready", W'(in_ready), W'(0));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("post_valid", W'(out_valid), W'(0));
        check("post_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0] rop;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_result", out_result, '0);
        check("rst_out_carry", W'(out_carry), W'(0));
        check("rst_out_err", W'(out_err), W'(0));
        check("rst_slice", W'({slice_a, slice_b, slice_sel}), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations.
        do_op({{64{1'b1}}, 64'h0}, {16{8'hF0}}, 3'b000, 0);
        check("and_literal", out_result, {{8{8'hF0}}, 64'h0});
        do_op({2{64'h0123456789ABCDEF}}, {2{64'h0123456789ABCDEF}}, 3'b010, 0);
        do_op('0, '0, 3'b011, 0);
        do_op(W'(1), W'(1) << (W - 1), 3'b001, 0);
        do_op({W{1'b1}}, '0, 3'b100, 0);
        do_op(W'(7), {W{1'b1}}, 3'b100, 1);
        check("inc7_literal", out_result, W'(8));
        do_op({W{1'b1}}, {W{1'b1}}, 3'b101, 0);
        do_op('0, '0, 3'b111, 1);

        // Asynchronous reset in the middle of an INC.
        in_valid = 1'b1;
        in_a     = {$urandom, $urandom, $urandom, $urandom};
        in_op    = 3'b100;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (51) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_slice", W'({slice_a, slice_b, slice_sel}), W'(0));
        check("abort_out_result", out_result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(W'(64'h0000_0000_FFFF_FFFF), '0, 3'b100, 0);

        // Randomized operations, including illegal opcodes.
        for (int n = 0; n < 14; n++) begin
            ra  = {$urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            rop = 3'($urandom_range(0, 7));
            if (n % 4 == 1) ra = {W{1'b1}} >> $urandom_range(0, 3);
            do_op(ra, rb, rop, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
